// File: rtl/video_pkg.sv
// Shared definitions for the HDMI video-path stages.
// Holds combine-rule encodings, default geometry and a channel-slice helper.
`ifndef VIDEO_CH_SLICE
`define VIDEO_CH_SLICE(k, w) (k)*(w) +: (w)
`endif

package video_pkg;

  localparam int VIDEO_DATA_W = 8;
  localparam int VIDEO_CH     = 3;

  typedef enum logic [1:0] {
    MODE_AND = 2'd0,
    MODE_OR  = 2'd1,
    MODE_MAJ = 2'd2,
    MODE_CH0 = 2'd3
  } mode_e;

endpackage

// File: rtl/video_sync_delay.sv
// N-stage delay line for the de/hsync/vsync trio so timing stays aligned
// with a pixel pipeline of the same depth.
module video_sync_delay #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_de,
  input  logic in_hsync,
  input  logic in_vsync,
  output logic out_de,
  output logic out_hsync,
  output logic out_vsync
);

  logic [2:0] pipe_r [N];

  // Shift {de, hsync, vsync} one stage per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pipe_r[i] <= 3'b000;
      end
    end else begin
      pipe_r[0] <= {in_de, in_hsync, in_vsync};
      for (int i = 1; i < N; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign out_de    = pipe_r[N-1][2];
  assign out_hsync = pipe_r[N-1][1];
  assign out_vsync = pipe_r[N-1][0];

endmodule

// File: rtl/video_binarize.sv
// Window threshold per channel, combined into a foreground bit that drives
// an all-ones/all-zeros pixel, plus a saturating per-frame foreground count.
module video_binarize
  import video_pkg::*;
#(
  parameter int DATA_W = VIDEO_DATA_W,
  parameter int CH     = VIDEO_CH,
  parameter int CNT_W  = 24
) (
  input  logic                 rx_pclk,
  input  logic                 rst,
  input  logic                 in_de,
  input  logic                 in_hsync,
  input  logic                 in_vsync,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic [CH*DATA_W-1:0] thr_lo,
  input  logic [CH*DATA_W-1:0] thr_hi,
  input  logic [1:0]           mode,
  input  logic                 invert,
  output logic                 out_de,
  output logic                 out_hsync,
  output logic                 out_vsync,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_mask,
  output logic [CNT_W-1:0]     fg_count,
  output logic                 frame_done
);

  localparam int PIX_W = CH * DATA_W;
  localparam int POP_W = $clog2(CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PIX_W-1:0] lo_r;
  logic [PIX_W-1:0] hi_r;
  mode_e            mode_r;
  logic             invert_r;
  logic             vs_prev_r;
  logic             vs_rise_s;

  logic [CH-1:0]    hit_s;
  logic [CH-1:0]    hit_r;
  logic             de1_r;
  mode_e            mode1_r;
  logic             invert1_r;

  logic [POP_W-1:0] pop_s;
  logic             fg_raw_s;
  logic             fg_s;
  logic             mask_s;

  logic [CNT_W-1:0] acc_r;
  logic [CNT_W-1:0] acc_inc_s;
  logic [CNT_W-1:0] acc_next_s;
  logic             ovs_prev_r;
  logic             frame_end_s;

  assign vs_rise_s = in_vsync & ~vs_prev_r;

  // Shadow config: only a frame start may change the active thresholds.
  always_ff @(posedge rx_pclk or posedge rst) begin
    if (rst) begin
      lo_r      <= {PIX_W{1'b0}};
      hi_r      <= {PIX_W{1'b1}};
      mode_r    <= MODE_AND;
      invert_r  <= 1'b0;
      vs_prev_r <= 1'b0;
    end else begin
      vs_prev_r <= in_vsync;
      if (vs_rise_s) begin
        lo_r     <= thr_lo;
        hi_r     <= thr_hi;
        mode_r   <= mode_e'(mode);
        invert_r <= invert;
      end
    end
  end

  // Inclusive per-channel window test; lo > hi simply never matches.
  always_comb begin
    hit_s = {CH{1'b0}};
    for (int k = 0; k < CH; k++) begin
      hit_s[k] = (lo_r[`VIDEO_CH_SLICE(k, DATA_W)] <= in_data[`VIDEO_CH_SLICE(k, DATA_W)]) &&
                 (in_data[`VIDEO_CH_SLICE(k, DATA_W)] <= hi_r[`VIDEO_CH_SLICE(k, DATA_W)]);
    end
  end

  // Stage 1: hits travel with the config that produced them.
  always_ff @(posedge rx_pclk or posedge rst) begin
    if (rst) begin
      hit_r     <= {CH{1'b0}};
      de1_r     <= 1'b0;
      mode1_r   <= MODE_AND;
      invert1_r <= 1'b0;
    end else begin
      hit_r     <= hit_s;
      de1_r     <= in_de;
      mode1_r   <= mode_r;
      invert1_r <= invert_r;
    end
  end

  // Combine channel hits into one foreground decision.
  always_comb begin
    pop_s = {POP_W{1'b0}};
    for (int k = 0; k < CH; k++) begin
      pop_s = pop_s + POP_W'(hit_r[k]);
    end
    case (mode1_r)
      MODE_AND: fg_raw_s = &hit_r;
      MODE_OR:  fg_raw_s = |hit_r;
      MODE_MAJ: fg_raw_s = (pop_s > POP_W'(CH / 2));
      MODE_CH0: fg_raw_s = hit_r[0];
      default:  fg_raw_s = 1'b0;
    endcase
    fg_s   = fg_raw_s ^ invert1_r;
    mask_s = fg_s & de1_r;
  end

  // Stage 2: blanking always yields a zero pixel.
  always_ff @(posedge rx_pclk or posedge rst) begin
    if (rst) begin
      out_mask <= 1'b0;
      out_data <= {PIX_W{1'b0}};
    end else begin
      out_mask <= mask_s;
      out_data <= {PIX_W{mask_s}};
    end
  end

  video_sync_delay #(
    .N (2)
  ) u_sync_delay (
    .clk       (rx_pclk),
    .rst       (rst),
    .in_de     (in_de),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .out_de    (out_de),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync)
  );

  assign frame_end_s = out_vsync & ~ovs_prev_r;

  // Saturating accumulate of the current output mask.
  always_comb begin
    if (acc_r == CNT_MAX) begin
      acc_inc_s = acc_r;
    end else begin
      acc_inc_s = acc_r + CNT_W'(1'b1);
    end
    if (out_mask) begin
      acc_next_s = acc_inc_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Frame counter; an output-side vsync rise closes the frame.
  always_ff @(posedge rx_pclk or posedge rst) begin
    if (rst) begin
      acc_r      <= {CNT_W{1'b0}};
      fg_count   <= {CNT_W{1'b0}};
      frame_done <= 1'b0;
      ovs_prev_r <= 1'b0;
    end else begin
      ovs_prev_r <= out_vsync;
      frame_done <= frame_end_s;
      if (frame_end_s) begin
        fg_count <= acc_next_s;
        acc_r    <= {CNT_W{1'b0}};
      end else begin
        acc_r    <= acc_next_s;
      end
    end
  end

endmodule
